// File: rtl/k_fftsequencer_if.sv
// Bundle between the FFT sequencer and the RAM / twiddle ROM / butterfly it drives.
// K_FFTSEQ_INVERSE_EN adds the inverse request and the tw_conj twiddle-conjugate flag.
interface k_fftsequencer_if #(
    parameter int LOG2N = 10
);
    logic                 start;
    logic [2*LOG2N-1:0]   scale_sched;
    logic                 busy;
    logic                 done;
    logic [LOG2N-1:0]     stage;
    logic                 rd_en;
    logic [LOG2N-1:0]     rd_addr0;
    logic [LOG2N-1:0]     rd_addr1;
    logic [LOG2N-2:0]     tw_idx;
    logic [1:0]           scaling;
    logic                 wr_en;
    logic [LOG2N-1:0]     wr_addr0;
    logic [LOG2N-1:0]     wr_addr1;
`ifdef K_FFTSEQ_INVERSE_EN
    logic                 inverse;
    logic                 tw_conj;

    modport master (
        input  start, scale_sched, inverse,
        output busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_idx, scaling,
               wr_en, wr_addr0, wr_addr1, tw_conj
    );
    modport slave (
        output start, scale_sched, inverse,
        input  busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_idx, scaling,
               wr_en, wr_addr0, wr_addr1, tw_conj
    );
`else
    modport master (
        input  start, scale_sched,
        output busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_idx, scaling,
               wr_en, wr_addr0, wr_addr1
    );
    modport slave (
        output start, scale_sched,
        input  busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_idx, scaling,
               wr_en, wr_addr0, wr_addr1
    );
`endif
endinterface

// File: rtl/k_fftsequencer.sv
// In-place radix-2 DIT FFT address/twiddle/scaling sequencer with write-back delay line.
// Optional K_FFTSEQ_INVERSE_EN: latches an inverse request and drives tw_conj while busy.
//
// state  | meaning
// IDLE   | waiting for start; outputs quiet
// ISSUE  | one butterfly read per cycle, b = 0..N/2-1 of stage s
// DRAIN  | PIPE_LAT cycles with no reads so stage s writes land before stage s+1 reads
// FINISH | one-cycle done pulse
module k_fftsequencer #(
    parameter int LOG2N    = 10,
    parameter int PIPE_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    k_fftsequencer_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    localparam int              CW       = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(PIPE_LAT - 1);
    localparam logic [LOG2N-2:0] B_LAST  = '1;
    localparam logic [LOG2N-1:0] S_LAST  = LOG2N'(LOG2N - 1);

    state_t               state, state_nxt;
    logic [LOG2N-2:0]     b;
    logic [LOG2N-1:0]     s;
    logic [CW-1:0]        cnt;
    logic [2*LOG2N-1:0]   sched_q;
    logic                 inv_q;

    logic                 rd_en, busy, done;
    logic [LOG2N-1:0]     addr0, addr1, b_ext, half, lo, tw_full;
    logic [LOG2N-2:0]     tw;
    logic [1:0]           scaling;

    logic                 pipe_en [PIPE_LAT];
    logic [LOG2N-1:0]     pipe_a0 [PIPE_LAT];
    logic [LOG2N-1:0]     pipe_a1 [PIPE_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b       <= '0;
            s       <= '0;
            cnt     <= '0;
            sched_q <= '0;
            inv_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    sched_q <= bus.scale_sched;
                    s       <= '0;
                    b       <= '0;
`ifdef K_FFTSEQ_INVERSE_EN
                    inv_q   <= bus.inverse;
`else
                    inv_q   <= 1'b0;
`endif
                end
                ISSUE: begin
                    b <= b + 1'b1;
                    if (b == B_LAST) cnt <= CNT_LOAD;
                end
                DRAIN: begin
                    if (cnt != '0)       cnt <= cnt - 1'b1;
                    else if (s != S_LAST) s  <= s + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ISSUE;
            ISSUE:   if (b == B_LAST) state_nxt = DRAIN;
            DRAIN:   if (cnt == '0) state_nxt = (s == S_LAST) ? FINISH : ISSUE;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Addresses are forced to zero outside ISSUE so the delay line carries clean zeros too.
    always_comb begin
        rd_en   = (state == ISSUE);
        busy    = (state == ISSUE) || (state == DRAIN);
        done    = (state == FINISH);
        scaling = sched_q[{s, 1'b0} +: 2];
        b_ext   = {1'b0, b};
        half    = LOG2N'(1) << s;
        lo      = b_ext & (half - 1'b1);
        addr0   = '0;
        addr1   = '0;
        tw_full = '0;
        if (rd_en) begin
            addr0   = ((b_ext >> s) << (s + 1'b1)) | lo;
            addr1   = addr0 | half;
            tw_full = lo << (S_LAST - s);
        end
        tw = tw_full[LOG2N-2:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_en[i] <= 1'b0;
                pipe_a0[i] <= '0;
                pipe_a1[i] <= '0;
            end
        end else begin
            pipe_en[0] <= rd_en;
            pipe_a0[0] <= addr0;
            pipe_a1[0] <= addr1;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_en[i] <= pipe_en[i-1];
                pipe_a0[i] <= pipe_a0[i-1];
                pipe_a1[i] <= pipe_a1[i-1];
            end
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.stage    = s;
    assign bus.rd_en    = rd_en;
    assign bus.rd_addr0 = addr0;
    assign bus.rd_addr1 = addr1;
    assign bus.tw_idx   = tw;
    assign bus.scaling  = scaling;
    assign bus.wr_en    = pipe_en[PIPE_LAT-1];
    assign bus.wr_addr0 = pipe_a0[PIPE_LAT-1];
    assign bus.wr_addr1 = pipe_a1[PIPE_LAT-1];
`ifdef K_FFTSEQ_INVERSE_EN
    assign bus.tw_conj  = busy & inv_q;
`endif
endmodule

// File: tb/tb_k_fftsequencer.sv
// Self-checking bench for k_fftsequencer (N=8, PIPE_LAT=4): directed and randomized runs
// against a cycle-indexed arithmetic model of the FFT schedule.
module tb_k_fftsequencer;
    localparam int LOG2N    = 3;
    localparam int PIPE_LAT = 4;
    localparam int N        = 1 << LOG2N;
    localparam int HALFN    = N / 2;
    localparam int SLOT     = HALFN + PIPE_LAT;
    localparam int T_DONE   = LOG2N * SLOT + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    k_fftsequencer_if #(.LOG2N(LOG2N)) bus ();
    k_fftsequencer #(.LOG2N(LOG2N), .PIPE_LAT(PIPE_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    int idle_stage;
    int idle_scaling;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Read issued at run cycle c (cycle 0 = start accepted), from the stage/slot arithmetic.
    task automatic model_read(input int c, output int en, output int a0, output int a1, output int tw);
        int k, p, half;
        en = 0; a0 = 0; a1 = 0; tw = 0;
        if (c >= 1 && c < T_DONE) begin
            k = (c - 1) / SLOT;
            p = (c - 1) % SLOT;
            if (p < HALFN) begin
                half = 1 << k;
                en   = 1;
                a0   = (p / half) * 2 * half + (p % half);
                a1   = a0 + half;
                tw   = (p % half) * (1 << (LOG2N - 1 - k));
            end
        end
    endtask

    task automatic check_cycle(input int c, input int sched, input int inv);
        int e_busy, e_done, e_stage, e_scal, r_en, r0, r1, rtw, w_en, w0, w1, wtw;
        if (c == 0) begin
            e_busy = 0; e_done = 0; e_stage = idle_stage; e_scal = idle_scaling;
        end else if (c == T_DONE) begin
            e_busy = 0; e_done = 1; e_stage = LOG2N - 1;
            e_scal = (sched >> (2 * (LOG2N - 1))) & 3;
        end else begin
            e_busy = 1; e_done = 0; e_stage = (c - 1) / SLOT;
            e_scal = (sched >> (2 * e_stage)) & 3;
        end
        model_read(c, r_en, r0, r1, rtw);
        model_read(c - PIPE_LAT, w_en, w0, w1, wtw);
        chk($sformatf("c%0d busy", c),     32'(bus.busy),     32'(e_busy));
        chk($sformatf("c%0d done", c),     32'(bus.done),     32'(e_done));
        chk($sformatf("c%0d stage", c),    32'(bus.stage),    32'(e_stage));
        chk($sformatf("c%0d scaling", c),  32'(bus.scaling),  32'(e_scal));
        chk($sformatf("c%0d rd_en", c),    32'(bus.rd_en),    32'(r_en));
        chk($sformatf("c%0d rd_addr0", c), 32'(bus.rd_addr0), 32'(r0));
        chk($sformatf("c%0d rd_addr1", c), 32'(bus.rd_addr1), 32'(r1));
        chk($sformatf("c%0d tw_idx", c),   32'(bus.tw_idx),   32'(rtw));
        chk($sformatf("c%0d wr_en", c),    32'(bus.wr_en),    32'(w_en));
        chk($sformatf("c%0d wr_addr0", c), 32'(bus.wr_addr0), 32'(w0));
        chk($sformatf("c%0d wr_addr1", c), 32'(bus.wr_addr1), 32'(w1));
`ifdef K_FFTSEQ_INVERSE_EN
        chk($sformatf("c%0d tw_conj", c),  32'(bus.tw_conj),  32'(e_busy & inv));
`else
        if (inv < 0) chk("inv arg", 32'(inv), 32'(0));
`endif
    endtask

    // mode 0: clean start only; 1: extra starts at cycles 3 and 10; 2: random extra starts.
    // abort_at > 0 asserts rst at that run cycle and ends the run there.
    task automatic do_run(input int sched, input int inv, input int mode, input int abort_at);
        for (int c = 0; c <= T_DONE; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                bus.start       = 1'b1;
                bus.scale_sched = (2*LOG2N)'(sched);
            end else begin
                bus.start       = (mode == 1) ? (c == 3 || c == 10)
                                : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
                bus.scale_sched = (2*LOG2N)'($urandom);
            end
`ifdef K_FFTSEQ_INVERSE_EN
            bus.inverse = (c == 0) ? inv[0] : 1'($urandom);
`endif
            if (abort_at > 0 && c == abort_at) begin
                bus.start = 1'b0;
                rst = 1'b1;
                #1;
                chk("abort wr_en", 32'(bus.wr_en), 32'(0));
                chk("abort rd_en", 32'(bus.rd_en), 32'(0));
                chk("abort busy",  32'(bus.busy),  32'(0));
                idle_stage   = 0;
                idle_scaling = 0;
                @(negedge clk);
                check_cycle(0, 0, 0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            @(negedge clk);
            check_cycle(c, sched, inv);
        end
        bus.start    = 1'b0;
        idle_stage   = LOG2N - 1;
        idle_scaling = (sched >> (2 * (LOG2N - 1))) & 3;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.start       = 1'b0;
            bus.scale_sched = (2*LOG2N)'($urandom);
            @(negedge clk);
            check_cycle(0, 0, 0);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.scale_sched = '0;
`ifdef K_FFTSEQ_INVERSE_EN
        bus.inverse     = 1'b0;
`endif
        idle_stage   = 0;
        idle_scaling = 0;
        @(negedge clk);
        check_cycle(0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);

        do_run(6'b11_01_10, 1, 0, 0);
        idle_cycles(3);
        do_run(6'b11_01_10, 0, 1, 0);
        do_run(int'($urandom_range(0, 63)), int'($urandom_range(0, 1)), 2, 0);
        do_run(int'($urandom_range(0, 63)), 1, 0, 6);
        do_run(6'b11_01_10, 0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            idle_cycles(int'($urandom_range(0, 3)));
            do_run(int'($urandom_range(0, 63)), int'($urandom_range(0, 1)), 2, 0);
        end
        do_run(int'($urandom_range(0, 63)), 0, 2, int'($urandom_range(1, T_DONE - 1)));
        do_run(int'($urandom_range(0, 63)), 1, 2, 0);
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
